// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } fetch_state_t;

    localparam logic [31:0] START_PC_DEFAULT = 32'h8002_0000;
    localparam logic [31:0] INSN_NOP         = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES       = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry {pc, insn} FIFO feeding decode; head is read straight from registered storage.
// Latency: a push is visible at the head the cycle after it is written (when the FIFO was empty).
// Backpressure: none internally; the caller reserves a slot before requesting, so push never sees full.
// Ports: clock_i/reset_n_i (sync active-low), push_i + push_pc_i/push_insn_i, pop_i, flush_i,
//        head_pc_o/head_insn_o (entry at read pointer), count_o (occupancy).
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clock_i,
    input  logic          reset_n_i,
    input  logic          push_i,
    input  logic [31:0]   push_pc_i,
    input  logic [31:0]   push_insn_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [31:0]   head_pc_o,
    output logic [31:0]   head_insn_o,
    output logic [CW-1:0] count_o
);

    logic [31:0]   pc_q   [DEPTH];
    logic [31:0]   insn_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    // DEPTH is a power of two, so the pointers wrap on plain overflow.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                insn_q[i] <= INSN_NOP;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                pc_q[wr_ptr_q]   <= push_pc_i;
                insn_q[wr_ptr_q] <= push_insn_i;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_pc_o   = pc_q[rd_ptr_q];
    assign head_insn_o = insn_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/fetch.sv
// Instruction fetch: holds the PC, issues one-outstanding word reads, buffers {pc, insn} for decode.
// Latency: request handshake at T, response at T+1, enable_decode at T+2; peak one insn per 2 cycles.
// Backpressure: stall holds the FIFO head; requests stop once every FIFO slot is full or reserved.
// Ports: clock/reset_n (sync active-low); mem_req_valid/mem_req_ready/mem_addr request channel;
//        mem_rsp_valid/mem_rsp_data response; stall, redirect/redirect_pc from downstream;
//        pc_out/insn_out/enable_decode to decode.
module fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] START_PC = START_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc_out,
    output logic [31:0] insn_out,
    output logic        enable_decode
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state_q,    state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q,   req_pc_d;
    logic [CW-1:0] count;
    logic          req_hs;
    logic          push;
    logic          pop;

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= START_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;

        unique case (state_q)
            IDLE: state_d = REQ;
            // A request accepted in the same cycle as a redirect is already in
            // flight; its response must be swallowed in DROP.
            REQ:  if (req_hs) state_d = redirect ? DROP : WAIT;
            WAIT: begin
                if (mem_rsp_valid)  state_d = REQ;
                else if (redirect)  state_d = DROP;
            end
            DROP: if (mem_rsp_valid) state_d = REQ;
            default: state_d = IDLE;
        endcase

        if (req_hs) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + WORD_BYTES;
        end
        if (redirect) begin
            fetch_pc_d = redirect_pc & ~32'h3;
        end
    end

    // Output logic
    always_comb begin
        // Only REQ can raise valid, and count cannot grow while in REQ, so
        // valid stays up until the handshake.
        mem_req_valid = (state_q == REQ) && (count < CW'(DEPTH));
        mem_addr      = fetch_pc_q;
        req_hs        = mem_req_valid && mem_req_ready;
        push          = (state_q == WAIT) && mem_rsp_valid && !redirect;
        enable_decode = (count != '0);
        pop           = enable_decode && !stall;
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock_i     (clock),
        .reset_n_i   (reset_n),
        .push_i      (push),
        .push_pc_i   (req_pc_q),
        .push_insn_i (mem_rsp_data),
        .pop_i       (pop),
        .flush_i     (redirect),
        .head_pc_o   (pc_out),
        .head_insn_o (insn_out),
        .count_o     (count)
    );

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch with a one-outstanding memory model that returns the address as data.
module tb_fetch;

    logic        clock;
    logic        reset_n;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_out;
    logic [31:0] insn_out;
    logic        enable_decode;

    int checks   = 0;
    int failures = 0;

    // memory model state
    bit          pend      = 0;
    logic [31:0] pend_addr = '0;
    int          pend_wait = 0;
    int          rsp_delay = 1;
    int          hs_count  = 0;

    fetch dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .pc_out        (pc_out),
        .insn_out      (insn_out),
        .enable_decode (enable_decode)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one cycle: note the handshake about to happen at this edge,
    // then drive the response for the new cycle.
    task automatic step();
        if (mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
            hs_count++;
            pend      = 1;
            pend_addr = mem_addr;
            pend_wait = rsp_delay;
        end
        @(posedge clock);
        #1;
        mem_rsp_valid = 1'b0;
        if (pend) begin
            pend_wait--;
            if (pend_wait == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = pend_addr;
                pend          = 0;
            end
        end
    endtask

    // Leaves the bench in the first cycle after reset release (state IDLE).
    task automatic do_reset();
        reset_n       = 1'b0;
        stall         = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = '0;
        mem_req_ready = 1'b1;
        rsp_delay     = 1;
        repeat (3) step();
    endtask

    task automatic start();
        do_reset();
        reset_n  = 1'b1;
        hs_count = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (enable_decode !== 1'b0) begin failures++; $display("FAIL rst_en got=%0b exp=0", enable_decode); end
        checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", pc_out); end
        checks++; if (insn_out !== 32'h0) begin failures++; $display("FAIL rst_insn got=%h exp=0", insn_out); end
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", mem_req_valid); end
        checks++; if (mem_addr !== 32'h8002_0000) begin failures++; $display("FAIL rst_addr got=%h exp=80020000", mem_addr); end
        reset_n = 1'b1;
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL c1_valid got=%0b exp=0", mem_req_valid); end
        step();
        checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL c2_valid got=%0b exp=1", mem_req_valid); end
        checks++; if (mem_addr !== 32'h8002_0000) begin failures++; $display("FAIL c2_addr got=%h exp=80020000", mem_addr); end
    endtask

    task automatic test_stream();
        logic        exp_en;
        logic [31:0] exp_pc;
        start();
        for (int c = 1; c <= 8; c++) begin
            exp_en = (c >= 4) && (c % 2 == 0);
            checks++; if (enable_decode !== exp_en) begin failures++; $display("FAIL stream_en c%0d got=%0b exp=%0b", c, enable_decode, exp_en); end
            if (exp_en) begin
                exp_pc = 32'h8002_0000 + 32'((c - 4) * 2);
                checks++; if (pc_out !== exp_pc) begin failures++; $display("FAIL stream_pc c%0d got=%h exp=%h", c, pc_out, exp_pc); end
                checks++; if (insn_out !== exp_pc) begin failures++; $display("FAIL stream_insn c%0d got=%h exp=%h", c, insn_out, exp_pc); end
            end
            step();
        end
    endtask

    task automatic test_stall();
        start();
        stall = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            if (c >= 6) begin
                checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_valid c%0d got=%0b exp=0", c, mem_req_valid); end
            end
            step();
        end
        checks++; if (hs_count !== 2) begin failures++; $display("FAIL stall_hs got=%0d exp=2", hs_count); end
        checks++; if (enable_decode !== 1'b1) begin failures++; $display("FAIL stall_en got=%0b exp=1", enable_decode); end
        checks++; if (pc_out !== 32'h8002_0000) begin failures++; $display("FAIL stall_head0 got=%h exp=80020000", pc_out); end
        stall = 1'b0;
        step();
        checks++; if (pc_out !== 32'h8002_0004) begin failures++; $display("FAIL stall_head1 got=%h exp=80020004", pc_out); end
        checks++; if (insn_out !== 32'h8002_0004) begin failures++; $display("FAIL stall_insn1 got=%h exp=80020004", insn_out); end
        checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8002_0008) begin failures++; $display("FAIL stall_resume got=%0b/%h exp=1/80020008", mem_req_valid, mem_addr); end
        step();
        checks++; if (enable_decode !== 1'b0) begin failures++; $display("FAIL stall_drain got=%0b exp=0", enable_decode); end
        step();
        checks++; if (enable_decode !== 1'b1 || pc_out !== 32'h8002_0008) begin failures++; $display("FAIL stall_next got=%0b/%h exp=1/80020008", enable_decode, pc_out); end
    endtask

    task automatic test_redirect_wait();
        start();
        rsp_delay = 4;
        step();
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_1003;
        step();
        redirect = 1'b0;
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL rw_valid got=%0b exp=0", mem_req_valid); end
        checks++; if (mem_addr !== 32'h0000_1000) begin failures++; $display("FAIL rw_addr got=%h exp=00001000", mem_addr); end
        step();
        step();
        checks++; if (mem_rsp_valid !== 1'b1 || enable_decode !== 1'b0) begin failures++; $display("FAIL rw_late got=%0b/%0b exp=1/0", mem_rsp_valid, enable_decode); end
        rsp_delay = 1;
        step();
        checks++; if (enable_decode !== 1'b0) begin failures++; $display("FAIL rw_discard got=%0b exp=0", enable_decode); end
        checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h0000_1000) begin failures++; $display("FAIL rw_req got=%0b/%h exp=1/00001000", mem_req_valid, mem_addr); end
        step();
        step();
        checks++; if (enable_decode !== 1'b1 || pc_out !== 32'h0000_1000) begin failures++; $display("FAIL rw_pc got=%0b/%h exp=1/00001000", enable_decode, pc_out); end
        checks++; if (insn_out !== 32'h0000_1000) begin failures++; $display("FAIL rw_insn got=%h exp=00001000", insn_out); end
    endtask

    task automatic test_redirect_handshake();
        start();
        repeat (3) step();
        checks++; if (enable_decode !== 1'b1 || pc_out !== 32'h8002_0000) begin failures++; $display("FAIL rh_pre got=%0b/%h exp=1/80020000", enable_decode, pc_out); end
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_2000;
        step();
        redirect = 1'b0;
        stall    = 1'b0;
        checks++; if (enable_decode !== 1'b0) begin failures++; $display("FAIL rh_flush got=%0b exp=0", enable_decode); end
        checks++; if (mem_req_valid !== 1'b0 || mem_addr !== 32'h0000_2000) begin failures++; $display("FAIL rh_drop got=%0b/%h exp=0/00002000", mem_req_valid, mem_addr); end
        step();
        checks++; if (enable_decode !== 1'b0) begin failures++; $display("FAIL rh_stale got=%0b exp=0", enable_decode); end
        checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h0000_2000) begin failures++; $display("FAIL rh_req got=%0b/%h exp=1/00002000", mem_req_valid, mem_addr); end
        step();
        step();
        checks++; if (enable_decode !== 1'b1 || pc_out !== 32'h0000_2000) begin failures++; $display("FAIL rh_pc got=%0b/%h exp=1/00002000", enable_decode, pc_out); end
    endtask

    task automatic test_wrap();
        start();
        step();
        mem_req_ready = 1'b0;
        redirect      = 1'b1;
        redirect_pc   = 32'hFFFF_FFFC;
        step();
        redirect      = 1'b0;
        mem_req_ready = 1'b1;
        checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_req got=%0b/%h exp=1/fffffffc", mem_req_valid, mem_addr); end
        step();
        checks++; if (mem_addr !== 32'h0000_0000) begin failures++; $display("FAIL wrap_addr got=%h exp=00000000", mem_addr); end
        step();
        checks++; if (enable_decode !== 1'b1 || pc_out !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc got=%0b/%h exp=1/fffffffc", enable_decode, pc_out); end
        checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h0000_0000) begin failures++; $display("FAIL wrap_next got=%0b/%h exp=1/00000000", mem_req_valid, mem_addr); end
    endtask

    task automatic test_reset_midop();
        start();
        repeat (3) step();
        stall     = 1'b1;
        rsp_delay = 3;
        step();
        checks++; if (enable_decode !== 1'b1 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL mid_pre got=%0b/%0b exp=1/0", enable_decode, mem_req_valid); end
        reset_n = 1'b0;
        step();
        checks++; if (enable_decode !== 1'b0) begin failures++; $display("FAIL mid_en got=%0b exp=0", enable_decode); end
        checks++; if (pc_out !== 32'h0 || insn_out !== 32'h0) begin failures++; $display("FAIL mid_head got=%h/%h exp=0/0", pc_out, insn_out); end
        checks++; if (mem_addr !== 32'h8002_0000) begin failures++; $display("FAIL mid_addr got=%h exp=80020000", mem_addr); end
        reset_n   = 1'b1;
        rsp_delay = 1;
        stall     = 1'b0;
        step();
        checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8002_0000) begin failures++; $display("FAIL mid_req got=%0b/%h exp=1/80020000", mem_req_valid, mem_addr); end
        step();
        checks++; if (enable_decode !== 1'b0) begin failures++; $display("FAIL mid_ignore got=%0b exp=0", enable_decode); end
        step();
        checks++; if (enable_decode !== 1'b1 || pc_out !== 32'h8002_0000) begin failures++; $display("FAIL mid_pc got=%0b/%h exp=1/80020000", enable_decode, pc_out); end
    endtask

    initial begin
        reset_n       = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        stall         = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_handshake();
        test_wrap();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
